// File: rtl/sys_array_pkg.sv
// Shared types and helpers for the systolic array processing element.
// Optional build macro: SYS_PE_SATURATE_EN (saturating accumulators).
package sys_array_pkg;

  localparam int PE_DATA_WIDTH = 8;
  localparam int PE_ACC_WIDTH  = 32;

  typedef enum logic [0:0] {
    PE_PASS_SUM  = 1'b0,
    PE_LOCAL_ACC = 1'b1
  } pe_mode_e;

  typedef struct packed {
    logic               clamp;
    logic signed [63:0] val;
  } sat_res_t;

  // Add two sign-extended operands and clamp to a w-bit signed range.
  function automatic sat_res_t sat_add(
    input logic signed [63:0] a,
    input logic signed [63:0] b,
    input int unsigned        w
  );
    logic signed [64:0] s;
    logic signed [64:0] hi;
    logic signed [64:0] lo;
    sat_res_t           r;
    s = $signed({a[63], a}) + $signed({b[63], b});
    hi = (65'sd1 <<< (w - 1)) - 65'sd1;
    lo = -(65'sd1 <<< (w - 1));
    r.clamp = 1'b0;
    r.val   = s[63:0];
    if (s > hi) begin
      r.clamp = 1'b1;
      r.val   = hi[63:0];
    end else if (s < lo) begin
      r.clamp = 1'b1;
      r.val   = lo[63:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/sys_array_pe_weight_buf.sv
// Shadow/active weight pair with a registered load-chain forward.
// The shadow loads while the active weight keeps feeding the multiplier.
module sys_pe_weight_buf
  import sys_array_pkg::*;
#(
  parameter int DATA_WIDTH = PE_DATA_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  w_load,
  input  logic                  w_swap,
  input  logic [DATA_WIDTH-1:0] w_in,
  output logic [DATA_WIDTH-1:0] w_active,
  output logic [DATA_WIDTH-1:0] w_out,
  output logic                  w_load_out
);

  logic [DATA_WIDTH-1:0] shadow;

  // Swap reads the old shadow; w_out mirrors the updated shadow.
  always_ff @(posedge clock) begin
    if (reset) begin
      shadow     <= '0;
      w_active   <= '0;
      w_out      <= '0;
      w_load_out <= 1'b0;
    end else begin
      if (w_load) shadow <= w_in;
      if (w_swap) w_active <= shadow;
      w_out      <= w_load ? w_in : shadow;
      w_load_out <= w_load;
    end
  end

endmodule

// File: rtl/sys_array_pe.sv
// Double-buffered systolic PE: pass-sum or local-accumulate modes.
// Optional build macro: SYS_PE_SATURATE_EN (clamp both adders).
module sys_array_pe
  import sys_array_pkg::*;
#(
  parameter int DATA_WIDTH = PE_DATA_WIDTH,
  parameter int ACC_WIDTH  = PE_ACC_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  mode,
  input  logic                  w_load,
  input  logic                  w_swap,
  input  logic [DATA_WIDTH-1:0] w_in,
  output logic [DATA_WIDTH-1:0] w_out,
  output logic                  w_load_out,
  input  logic                  a_valid_in,
  input  logic [DATA_WIDTH-1:0] a_in,
  output logic                  a_valid_out,
  output logic [DATA_WIDTH-1:0] a_out,
  input  logic                  psum_valid_in,
  input  logic [ACC_WIDTH-1:0]  psum_in,
  output logic                  psum_valid_out,
  output logic [ACC_WIDTH-1:0]  psum_out,
  input  logic                  drain,
  output logic                  ovf
);

  logic [DATA_WIDTH-1:0]          w_act;
  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH-1:0]    p_ext;
  logic signed [ACC_WIDTH-1:0]    base;
  logic signed [ACC_WIDTH-1:0]    acc;
  logic signed [ACC_WIDTH-1:0]    sum0;
  logic signed [ACC_WIDTH-1:0]    sum1;
  logic                           clamp0;
  logic                           clamp1;
  logic                           is_acc;

  sys_pe_weight_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_wbuf (
    .clock     (clock),
    .reset     (reset),
    .w_load    (w_load),
    .w_swap    (w_swap),
    .w_in      (w_in),
    .w_active  (w_act),
    .w_out     (w_out),
    .w_load_out(w_load_out)
  );

  assign is_acc = (pe_mode_e'(mode) == PE_LOCAL_ACC);
  assign prod   = $signed(a_in) * $signed(w_act);
  assign p_ext  = ACC_WIDTH'(prod);
  assign base   = psum_valid_in ? $signed(psum_in) : '0;

`ifdef SYS_PE_SATURATE_EN
  sat_res_t r0;
  sat_res_t r1;

  // Clamping adders for the chain sum and the local accumulator.
  always_comb begin
    r0     = sat_add(64'(base), 64'(p_ext), ACC_WIDTH);
    r1     = sat_add(64'(acc), 64'(p_ext), ACC_WIDTH);
    sum0   = r0.val[ACC_WIDTH-1:0];
    sum1   = r1.val[ACC_WIDTH-1:0];
    clamp0 = r0.clamp;
    clamp1 = r1.clamp;
  end
`else
  // Wrapping adders; overflow only flagged on drain collisions.
  always_comb begin
    sum0   = base + p_ext;
    sum1   = acc + p_ext;
    clamp0 = 1'b0;
    clamp1 = 1'b0;
  end
`endif

  // Activation forward, partial-sum path, accumulator and sticky ovf.
  always_ff @(posedge clock) begin
    if (reset) begin
      a_out          <= '0;
      a_valid_out    <= 1'b0;
      psum_out       <= '0;
      psum_valid_out <= 1'b0;
      acc            <= '0;
      ovf            <= 1'b0;
    end else begin
      a_out       <= a_in;
      a_valid_out <= a_valid_in;
      if (is_acc) begin
        if (drain) begin
          psum_out       <= acc;
          psum_valid_out <= 1'b1;
          acc            <= a_valid_in ? p_ext : '0;
          if (psum_valid_in) ovf <= 1'b1;
        end else begin
          psum_out       <= psum_in;
          psum_valid_out <= psum_valid_in;
          if (a_valid_in) begin
            acc <= sum1;
            if (clamp1) ovf <= 1'b1;
          end
        end
      end else if (a_valid_in) begin
        psum_out       <= sum0;
        psum_valid_out <= 1'b1;
        if (clamp0) ovf <= 1'b1;
      end else begin
        psum_out       <= psum_in;
        psum_valid_out <= psum_valid_in;
      end
    end
  end

endmodule

// File: tb/tb_sys_array_pe.sv
// Directed bench for sys_array_pe (DATA_WIDTH=8, ACC_WIDTH=16).
// Expected saturation results follow SYS_PE_SATURATE_EN.
module tb_sys_array_pe;

  localparam int DW = 8;
  localparam int AW = 16;
`ifdef SYS_PE_SATURATE_EN
  localparam int SAT = 1;
`else
  localparam int SAT = 0;
`endif

  logic          clock = 1'b0;
  logic          reset;
  logic          mode;
  logic          w_load;
  logic          w_swap;
  logic [DW-1:0] w_in;
  logic [DW-1:0] w_out;
  logic          w_load_out;
  logic          a_valid_in;
  logic [DW-1:0] a_in;
  logic          a_valid_out;
  logic [DW-1:0] a_out;
  logic          psum_valid_in;
  logic [AW-1:0] psum_in;
  logic          psum_valid_out;
  logic [AW-1:0] psum_out;
  logic          drain;
  logic          ovf;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  sys_array_pe #(
    .DATA_WIDTH(DW),
    .ACC_WIDTH (AW)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .mode          (mode),
    .w_load        (w_load),
    .w_swap        (w_swap),
    .w_in          (w_in),
    .w_out         (w_out),
    .w_load_out    (w_load_out),
    .a_valid_in    (a_valid_in),
    .a_in          (a_in),
    .a_valid_out   (a_valid_out),
    .a_out         (a_out),
    .psum_valid_in (psum_valid_in),
    .psum_in       (psum_in),
    .psum_valid_out(psum_valid_out),
    .psum_out      (psum_out),
    .drain         (drain),
    .ovf           (ovf)
  );

  typedef struct {
    int rst; int md; int wl; int ws; int wi;
    int av;  int ai; int pv; int pi; int dr;
    int wo;  int wlo; int avo; int ao;
    int pvo; int po; int ov;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [35:0] pack_exp(vec_t v);
    return {DW'(v.wo), 1'(v.wlo), 1'(v.avo), DW'(v.ao),
            1'(v.pvo), AW'(v.po), 1'(v.ov)};
  endfunction

  function automatic logic [35:0] pack_act();
    return {w_out, w_load_out, a_valid_out, a_out,
            psum_valid_out, psum_out, ovf};
  endfunction

  task automatic chk(input string name,
                     input logic [35:0] act,
                     input logic [35:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic step(input int rst, input int md,
                      input int wl, input int ws, input int wi,
                      input int av, input int ai,
                      input int pv, input int pi, input int dr);
    reset         = 1'(rst);
    mode          = 1'(md);
    w_load        = 1'(wl);
    w_swap        = 1'(ws);
    w_in          = DW'(wi);
    a_valid_in    = 1'(av);
    a_in          = DW'(ai);
    psum_valid_in = 1'(pv);
    psum_in       = AW'(pi);
    drain         = 1'(dr);
    @(posedge clock);
    #1;
  endtask

  initial begin
    // rst md wl ws wi av ai pv pi dr | wo wlo avo ao pvo po ov
    vecs.push_back('{1,1,1,1,9,1,5,1,77,1, 0,0,0,0,0,0,0});
    vecs.push_back('{0,0,0,0,0,1,5,0,0,0, 0,0,1,5,1,0,0});
    vecs.push_back('{0,0,1,0,3,0,0,0,0,0, 3,1,0,0,0,0,0});
    vecs.push_back('{0,0,0,1,0,0,0,0,0,0, 3,0,0,0,0,0,0});
    vecs.push_back('{0,0,0,0,0,1,-4,1,100,0,
                     3,0,1,-4,1,88,0});
    vecs.push_back('{0,0,0,0,0,0,0,1,1234,0,
                     3,0,0,0,1,1234,0});
    vecs.push_back('{0,0,1,0,1,0,0,0,0,0, 1,1,0,0,0,0,0});
    vecs.push_back('{0,0,1,1,2,0,0,0,0,0, 2,1,0,0,0,0,0});
    vecs.push_back('{0,0,1,1,5,1,7,0,0,0, 5,1,1,7,1,7,0});
    vecs.push_back('{0,0,0,0,0,1,7,0,0,0, 5,0,1,7,1,14,0});
    vecs.push_back('{0,0,0,1,0,0,0,0,0,0, 5,0,0,0,0,0,0});
    vecs.push_back('{0,0,0,0,0,1,7,0,0,0, 5,0,1,7,1,35,0});
    vecs.push_back('{0,1,1,0,10,0,0,0,0,0, 10,1,0,0,0,0,0});
    vecs.push_back('{0,1,0,1,0,0,0,0,0,0, 10,0,0,0,0,0,0});
    vecs.push_back('{0,1,0,0,0,1,2,0,0,0, 10,0,1,2,0,0,0});
    vecs.push_back('{0,1,0,0,0,1,3,0,0,0, 10,0,1,3,0,0,0});
    vecs.push_back('{0,1,0,0,0,1,4,0,0,0, 10,0,1,4,0,0,0});
    vecs.push_back('{0,1,0,0,0,0,0,0,0,1, 10,0,0,0,1,90,0});
    vecs.push_back('{0,1,0,0,0,0,0,0,0,0, 10,0,0,0,0,0,0});
    vecs.push_back('{0,1,0,0,0,1,1,0,0,0, 10,0,1,1,0,0,0});
    vecs.push_back('{0,1,0,0,0,1,2,0,0,1, 10,0,1,2,1,10,0});
    vecs.push_back('{0,1,0,0,0,0,0,0,0,1, 10,0,0,0,1,20,0});
    vecs.push_back('{0,1,0,0,0,0,0,1,555,0,
                     10,0,0,0,1,555,0});
    vecs.push_back('{0,1,1,0,127,0,0,0,0,0,
                     127,1,0,0,0,0,0});
    vecs.push_back('{0,1,0,1,0,0,0,0,0,0,
                     127,0,0,0,0,0,0});
    vecs.push_back('{0,1,0,0,0,1,127,0,0,0,
                     127,0,1,127,0,0,0});
    vecs.push_back('{0,1,0,0,0,1,127,0,0,0,
                     127,0,1,127,0,0,0});
    vecs.push_back('{0,1,0,0,0,1,127,0,0,0,
                     127,0,1,127,0,0,SAT});
    vecs.push_back('{0,1,0,0,0,0,0,0,0,1,
                     127,0,0,0,1,
                     (SAT != 0) ? 32767 : -17149,SAT});
    vecs.push_back('{0,0,0,0,0,1,1,1,32767,0,
                     127,0,1,1,1,
                     (SAT != 0) ? 32767 : -32642,SAT});

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].md, vecs[i].wl,
           vecs[i].ws, vecs[i].wi, vecs[i].av,
           vecs[i].ai, vecs[i].pv, vecs[i].pi,
           vecs[i].dr);
      chk($sformatf("vec%0d", i), pack_act(),
          pack_exp(vecs[i]));
    end

    // Reset mid-run with every input high wins.
    step(1, 1, 1, 1, 8'h55, 1, 3, 1, 999, 1);
    chk("reset_all", pack_act(), 36'h0);
    // Weights are zero after reset: product is 0.
    step(0, 0, 0, 0, 0, 1, 5, 0, 0, 0);
    chk("post_reset_w0", pack_act(),
        {8'd0, 1'b0, 1'b1, 8'd5, 1'b1, 16'd0, 1'b0});

    // Drain collision: local acc wins, ovf sticky.
    step(0, 1, 1, 0, 3, 0, 0, 0, 0, 0);
    step(0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 1, 5, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 1, 999, 1);
    chk("collide", pack_act(),
        {8'd3, 1'b0, 1'b0, 8'd0, 1'b1, 16'd15, 1'b1});
    for (int k = 0; k < 3; k++) begin
      step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      chk($sformatf("ovf_sticky%0d", k),
          {35'd0, ovf}, 36'd1);
    end
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("acc_cleared", pack_act(),
        {8'd3, 1'b0, 1'b0, 8'd0, 1'b1, 16'd0, 1'b1});
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("ovf_reset", pack_act(), 36'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
